// File: rtl/stack_pointer_unit_if.sv
// Decode/memory-stage handshake bundle for the stack pointer unit.
// The decode side is the master; the unit itself is the slave.
interface stack_pointer_unit_if;
    logic        stall;
    logic        push;
    logic        pop;
    logic        call;
    logic        ret;
    logic        rti;
    logic        int_req;
    logic [31:0] sp_addr;
    logic [31:0] sp_value;
    logic        stack_or_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [1:0]  word_sel;
    logic        pc_to_stack_int;
    logic        ret_pop;
    logic        rti_pop;
    logic        busy;
    logic        stack_err;

    modport master (
        output stall, push, pop, call, ret, rti, int_req,
        input  sp_addr, sp_value, stack_or_data, mem_wr, mem_rd, word_sel,
               pc_to_stack_int, ret_pop, rti_pop, busy, stack_err
    );

    modport slave (
        input  stall, push, pop, call, ret, rti, int_req,
        output sp_addr, sp_value, stack_or_data, mem_wr, mem_rd, word_sel,
               pc_to_stack_int, ret_pop, rti_pop, busy, stack_err
    );
endinterface

// File: rtl/stack_pointer_unit.sv
// Stack pointer register and sequencer for PUSH/POP, CALL/RET and INT/RTI
// stack accesses; all access outputs are registered.
module stack_pointer_unit #(
    parameter logic [31:0] SP_INIT = 32'h0000_0FFF
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_pointer_unit_if.slave  spu
);

    typedef enum logic [1:0] {S_IDLE, S_W2, S_W3} state_e;
    typedef enum logic [2:0] {OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_INT, OP_RTI} op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] sp_q, sp_d;
    logic        int_pending_q, int_pending_d;

    logic [31:0] sp_addr_q, sp_addr_d;
    logic        sod_q, sod_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_rd_q, mem_rd_d;
    logic [1:0]  word_sel_q, word_sel_d;
    logic        pc_int_q, pc_int_d;
    logic        ret_pop_q, ret_pop_d;
    logic        rti_pop_q, rti_pop_d;
    logic        stack_err_q, stack_err_d;

    logic        accept;
    logic        int_now;
    logic        cmd_valid;
    op_e         cmd_op;
    logic        issue;
    op_e         cur_op;
    logic [1:0]  word_idx;
    logic [1:0]  nwords;
    logic        is_write;
    logic [31:0] pop_addr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_PUSH;
            sp_q          <= SP_INIT;
            int_pending_q <= 1'b0;
            sp_addr_q     <= SP_INIT;
            sod_q         <= 1'b1;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            word_sel_q    <= '0;
            pc_int_q      <= 1'b0;
            ret_pop_q     <= 1'b0;
            rti_pop_q     <= 1'b0;
            stack_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sp_q          <= sp_d;
            int_pending_q <= int_pending_d;
            sp_addr_q     <= sp_addr_d;
            sod_q         <= sod_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            word_sel_q    <= word_sel_d;
            pc_int_q      <= pc_int_d;
            ret_pop_q     <= ret_pop_d;
            rti_pop_q     <= rti_pop_d;
            stack_err_q   <= stack_err_d;
        end
    end

    // Next-state: command arbitration, sequencing and SP update
    always_comb begin
        accept  = ~spu.stall && (state_q == S_IDLE);
        int_now = int_pending_q | spu.int_req;

        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        if (int_now)       cmd_op = OP_INT;
        else if (spu.rti)  cmd_op = OP_RTI;
        else if (spu.ret)  cmd_op = OP_RET;
        else if (spu.call) cmd_op = OP_CALL;
        else if (spu.pop)  cmd_op = OP_POP;
        else if (spu.push) cmd_op = OP_PUSH;
        else               cmd_valid = 1'b0;

        issue    = (accept && cmd_valid) || (~spu.stall && (state_q != S_IDLE));
        cur_op   = (state_q == S_IDLE) ? cmd_op : op_q;
        word_idx = (state_q == S_IDLE) ? 2'd1 : ((state_q == S_W2) ? 2'd2 : 2'd3);
        is_write = (cur_op == OP_PUSH) || (cur_op == OP_CALL) || (cur_op == OP_INT);
        pop_addr = sp_q + 32'd1;

        case (cur_op)
            OP_CALL, OP_RET: nwords = 2'd2;
            OP_INT, OP_RTI:  nwords = 2'd3;
            default:         nwords = 2'd1;
        endcase

        state_d       = state_q;
        op_d          = op_q;
        sp_d          = sp_q;
        int_pending_d = int_pending_q | spu.int_req;

        if (accept && cmd_valid) begin
            op_d = cmd_op;
            if (cmd_op == OP_INT) int_pending_d = 1'b0;
        end

        if (issue) begin
            sp_d = is_write ? (sp_q - 32'd1) : pop_addr;
            if (word_idx == nwords)  state_d = S_IDLE;
            else if (word_idx == 2'd1) state_d = S_W2;
            else                     state_d = S_W3;
        end
    end

    // Output next values; a stalled edge repeats the previous cycle's outputs
    always_comb begin
        sp_addr_d   = sp_addr_q;
        sod_d       = sod_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        word_sel_d  = word_sel_q;
        pc_int_d    = pc_int_q;
        ret_pop_d   = ret_pop_q;
        rti_pop_d   = rti_pop_q;
        stack_err_d = stack_err_q;

        if (~spu.stall) begin
            sod_d       = 1'b1;
            mem_wr_d    = 1'b0;
            mem_rd_d    = 1'b0;
            word_sel_d  = '0;
            pc_int_d    = 1'b0;
            ret_pop_d   = 1'b0;
            rti_pop_d   = 1'b0;
            stack_err_d = 1'b0;

            if (issue) begin
                sp_addr_d   = is_write ? sp_q : pop_addr;
                sod_d       = 1'b0;
                mem_wr_d    = is_write;
                mem_rd_d    = ~is_write;
                pc_int_d    = (cur_op == OP_INT);
                ret_pop_d   = (cur_op == OP_RET);
                rti_pop_d   = (cur_op == OP_RTI);
                stack_err_d = ~is_write && (pop_addr > SP_INIT);

                // Reads unwind the write order: last word written is first read
                case (cur_op)
                    OP_CALL, OP_INT: word_sel_d = word_idx;
                    OP_RET:          word_sel_d = (word_idx == 2'd1) ? 2'd2 : 2'd1;
                    OP_RTI: begin
                        case (word_idx)
                            2'd1:    word_sel_d = 2'd3;
                            2'd2:    word_sel_d = 2'd2;
                            default: word_sel_d = 2'd1;
                        endcase
                    end
                    default:         word_sel_d = 2'd0;
                endcase
            end
        end
    end

    assign spu.sp_addr         = sp_addr_q;
    assign spu.sp_value        = sp_q;
    assign spu.stack_or_data   = sod_q;
    assign spu.mem_wr          = mem_wr_q;
    assign spu.mem_rd          = mem_rd_q;
    assign spu.word_sel        = word_sel_q;
    assign spu.pc_to_stack_int = pc_int_q;
    assign spu.ret_pop         = ret_pop_q;
    assign spu.rti_pop         = rti_pop_q;
    assign spu.busy            = (state_q != S_IDLE);
    assign spu.stack_err       = stack_err_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed and randomized bench for stack_pointer_unit against a
// word-list reference model of each stack operation.
module tb_stack_pointer_unit;

    localparam logic [31:0] INIT = 32'h0000_0FFF;
    localparam logic [7:0] PUSH = 8'h01, POP = 8'h02, CALL = 8'h04, RET = 8'h08,
                           RTI = 8'h10, INT = 8'h20, STALL = 8'h40, RST = 8'h80;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_pointer_unit_if spu();
    stack_pointer_unit #(.SP_INIT(INIT)) dut (.clk(clk), .rst(rst), .spu(spu));

    // One stack word access: direction, word selector and which op flag it raises
    typedef struct {
        bit       wr;
        bit [1:0] sel;
        int       kind;   // 0 none, 1 int, 2 ret, 3 rti
    } acc_t;

    acc_t        q[$];
    logic [31:0] m_sp;
    logic        m_int_pend;
    logic [31:0] e_addr;
    logic        e_sod, e_wr, e_rd, e_pci, e_ret, e_rti, e_busy, e_err;
    logic [1:0]  e_sel;

    int unsigned n_checks = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        rst         = v[7];
        spu.stall   = v[6];
        spu.int_req = v[5];
        spu.rti     = v[4];
        spu.ret     = v[3];
        spu.call    = v[2];
        spu.pop     = v[1];
        spu.push    = v[0];
    endtask

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_step();
        acc_t a;
        if (rst) begin
            q.delete();
            m_sp = INIT; m_int_pend = 1'b0; e_addr = INIT; e_sod = 1'b1;
            {e_wr, e_rd, e_pci, e_ret, e_rti, e_busy, e_err} = '0;
            e_sel = 2'd0;
        end else if (spu.stall) begin
            m_int_pend = m_int_pend | spu.int_req;
        end else begin
            if (q.size() == 0) begin
                if (m_int_pend || spu.int_req) begin
                    q.push_back('{1'b1, 2'd1, 1}); q.push_back('{1'b1, 2'd2, 1});
                    q.push_back('{1'b1, 2'd3, 1});
                    m_int_pend = 1'b0;
                end else if (spu.rti) begin
                    q.push_back('{1'b0, 2'd3, 3}); q.push_back('{1'b0, 2'd2, 3});
                    q.push_back('{1'b0, 2'd1, 3});
                end else if (spu.ret) begin
                    q.push_back('{1'b0, 2'd2, 2}); q.push_back('{1'b0, 2'd1, 2});
                end else if (spu.call) begin
                    q.push_back('{1'b1, 2'd1, 0}); q.push_back('{1'b1, 2'd2, 0});
                end else if (spu.pop) begin
                    q.push_back('{1'b0, 2'd0, 0});
                end else if (spu.push) begin
                    q.push_back('{1'b1, 2'd0, 0});
                end
            end else begin
                m_int_pend = m_int_pend | spu.int_req;
            end

            if (q.size() != 0) begin
                a = q.pop_front();
                if (a.wr) begin
                    e_addr = m_sp;
                    m_sp   = m_sp - 1;
                end else begin
                    m_sp   = m_sp + 1;
                    e_addr = m_sp;
                end
                e_sod = 1'b0; e_wr = a.wr; e_rd = !a.wr; e_sel = a.sel;
                e_pci = (a.kind == 1); e_ret = (a.kind == 2); e_rti = (a.kind == 3);
                e_err = !a.wr && (m_sp > INIT);
            end else begin
                e_sod = 1'b1; e_sel = 2'd0;
                {e_wr, e_rd, e_pci, e_ret, e_rti, e_err} = '0;
            end
            e_busy = (q.size() != 0);
        end
    endtask

    task automatic compare_all();
        check("sp_addr",   spu.sp_addr,               e_addr);
        check("sp_value",  spu.sp_value,              m_sp);
        check("stack_or_data", 32'(spu.stack_or_data), 32'(e_sod));
        check("mem_wr",    32'(spu.mem_wr),           32'(e_wr));
        check("mem_rd",    32'(spu.mem_rd),           32'(e_rd));
        check("word_sel",  32'(spu.word_sel),         32'(e_sel));
        check("pc_to_stack_int", 32'(spu.pc_to_stack_int), 32'(e_pci));
        check("ret_pop",   32'(spu.ret_pop),          32'(e_ret));
        check("rti_pop",   32'(spu.rti_pop),          32'(e_rti));
        check("busy",      32'(spu.busy),             32'(e_busy));
        check("stack_err", 32'(spu.stack_err),        32'(e_err));
    endtask

    task automatic cycle(input logic [7:0] v);
        drive(v);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] v;
        drive(8'h00);

        // Reset, push, pop
        cycle(RST);
        check("rst_addr", spu.sp_addr, 32'h0FFF);
        check("rst_sod", 32'(spu.stack_or_data), 32'd1);
        cycle(PUSH);
        check("push_addr", spu.sp_addr, 32'h0FFF);
        check("push_sp", spu.sp_value, 32'h0FFE);
        check("push_wr", 32'(spu.mem_wr), 32'd1);
        cycle(POP);
        check("pop_addr", spu.sp_addr, 32'h0FFF);
        check("pop_sp", spu.sp_value, 32'h0FFF);
        check("pop_err", 32'(spu.stack_err), 32'd0);

        // CALL then RET
        cycle(CALL);
        check("call1_addr", spu.sp_addr, 32'h0FFF);
        check("call1_busy", 32'(spu.busy), 32'd1);
        cycle(8'h00);
        check("call2_sel", 32'(spu.word_sel), 32'd2);
        check("call2_sp", spu.sp_value, 32'h0FFD);
        cycle(RET);
        check("ret1_addr", spu.sp_addr, 32'h0FFE);
        cycle(8'h00);
        check("ret2_sel", 32'(spu.word_sel), 32'd1);
        check("ret2_sp", spu.sp_value, 32'h0FFF);

        // INT then RTI
        cycle(INT); cycle(8'h00); cycle(8'h00);
        check("int3_addr", spu.sp_addr, 32'h0FFD);
        check("int3_sp", spu.sp_value, 32'h0FFC);
        cycle(RTI);
        check("rti1_sel", 32'(spu.word_sel), 32'd3);
        cycle(8'h00); cycle(8'h00);
        check("rti3_sp", spu.sp_value, 32'h0FFF);

        // Interrupt pulsed during CALL, push in CALL's last cycle dropped
        cycle(CALL);
        cycle(INT);
        check("callint_sp", spu.sp_value, 32'h0FFD);
        cycle(PUSH);
        check("pend_int1", spu.sp_addr, 32'h0FFD);
        check("pend_int1_flag", 32'(spu.pc_to_stack_int), 32'd1);
        cycle(8'h00); cycle(8'h00);
        check("pend_int3_sp", spu.sp_value, 32'h0FFA);
        cycle(8'h00);
        check("push_dropped", 32'(spu.stack_or_data), 32'd1);

        // Pop from an empty stack
        cycle(RST);
        cycle(POP);
        check("empty_addr", spu.sp_addr, 32'h1000);
        check("empty_err", 32'(spu.stack_err), 32'd1);
        cycle(8'h00);
        check("empty_err_pulse", 32'(spu.stack_err), 32'd0);

        // Stall inside INT, then reset mid-sequence
        cycle(RST); cycle(INT); cycle(8'h00);
        cycle(STALL); cycle(STALL);
        check("stall_addr", spu.sp_addr, 32'h0FFE);
        check("stall_sp", spu.sp_value, 32'h0FFD);
        check("stall_busy", 32'(spu.busy), 32'd1);
        cycle(8'h00);
        check("resume_sel", 32'(spu.word_sel), 32'd3);
        cycle(INT); cycle(8'h00);
        cycle(RST);
        check("midrst_sp", spu.sp_value, 32'h0FFF);
        check("midrst_busy", 32'(spu.busy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v = 8'h00;
            if ($urandom_range(0, 9) < 6) v = 8'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) v = v | (8'($urandom) & 8'h1F);
            if ($urandom_range(0, 15) == 0) v = v | INT;
            if ($urandom_range(0, 7) == 0)  v = v | STALL;
            if ($urandom_range(0, 99) < 2)  v = v | RST;
            cycle(v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
